// File: rtl/z80_bus_sync_if.sv
// Z80 pin bundle and the qualified bus record presented to the decoder.
interface z80_bus_sync_if;
    logic [15:0] z80_a;
    logic [7:0]  z80_d_in;
    logic        z80_rd;
    logic        z80_wr;
    logic        z80_mreq;
    logic        z80_iorq;
    logic        z80_m1;
    logic [15:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_rd_n;
    logic        bus_wr_n;
    logic        bus_mreq_n;
    logic        bus_iorq_n;
    logic        bus_m1_n;
    logic        cyc_start;
    logic        cyc_end;
    logic [2:0]  cyc_kind;
    logic [7:0]  glitch_cnt;
    logic [7:0]  err_cnt;

    modport slave (
        input  z80_a, z80_d_in, z80_rd, z80_wr,
        input  z80_mreq, z80_iorq, z80_m1,
        output bus_a, bus_d, bus_rd_n, bus_wr_n,
        output bus_mreq_n, bus_iorq_n, bus_m1_n,
        output cyc_start, cyc_end, cyc_kind,
        output glitch_cnt, err_cnt
    );

    modport master (
        output z80_a, z80_d_in, z80_rd, z80_wr,
        output z80_mreq, z80_iorq, z80_m1,
        input  bus_a, bus_d, bus_rd_n, bus_wr_n,
        input  bus_mreq_n, bus_iorq_n, bus_m1_n,
        input  cyc_start, cyc_end, cyc_kind,
        input  glitch_cnt, err_cnt
    );
endinterface

// File: rtl/z80_bus_sync.sv
// Z80 bus front end: strobe synchronisers, RD/WR glitch filter and
// one registered cycle record per Z80 read or write.
module z80_bus_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 2
) (
    input logic           clk,
    input logic           rst,
    z80_bus_sync_if.slave zb
);

    typedef enum logic [1:0] {
        IDLE, QUAL, ACTIVE, RELEASE
    } state_t;

    localparam logic [2:0] FILT_M1 = 3'(FILT - 1);

    localparam logic [2:0] K_IDLE = 3'd0;
    localparam logic [2:0] K_M1   = 3'd1;
    localparam logic [2:0] K_MRD  = 3'd2;
    localparam logic [2:0] K_MWR  = 3'd3;
    localparam logic [2:0] K_IORD = 3'd4;
    localparam logic [2:0] K_IOWR = 3'd5;
    localparam logic [2:0] K_UNDF = 3'd7;

    state_t state, state_nx;

    // strobe vector order: {m1, iorq, mreq, wr, rd}, all active-low
    logic [4:0] pins;
    logic [SYNC_STAGES-1:0][4:0] sy;
    logic [4:0] strb;
    logic [15:0] a_s;
    logic [7:0]  d_s;
    logic act;

    logic [4:0]  sh;
    logic [15:0] sh_a;
    logic [7:0]  sh_d;
    logic [2:0]  qcnt, qcnt_nx;
    logic [2:0]  rcnt, rcnt_nx;

    logic latch, enter, leave, glitch;
    logic [4:0]  src;
    logic [15:0] src_a;
    logic [7:0]  src_d;
    logic        rd_l, wr_l, both;
    logic [2:0]  kind;

    assign pins = {zb.z80_m1, zb.z80_iorq, zb.z80_mreq,
                   zb.z80_wr, zb.z80_rd};
    assign strb = sy[SYNC_STAGES-1];
    assign act  = ~strb[0] | ~strb[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sy  <= '1;
            a_s <= '0;
            d_s <= '0;
        end else begin
            sy  <= {sy[SYNC_STAGES-2:0], pins};
            a_s <= zb.z80_a;
            d_s <= zb.z80_d_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            qcnt  <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_nx;
            qcnt  <= qcnt_nx;
            rcnt  <= rcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        qcnt_nx  = qcnt;
        rcnt_nx  = rcnt;
        latch    = 1'b0;
        enter    = 1'b0;
        leave    = 1'b0;
        glitch   = 1'b0;
        unique case (state)
            IDLE: begin
                if (act) begin
                    latch   = 1'b1;
                    qcnt_nx = 3'd1;
                    if (FILT == 1) begin
                        enter    = 1'b1;
                        state_nx = ACTIVE;
                    end else begin
                        state_nx = QUAL;
                    end
                end
            end
            QUAL: begin
                if (act) begin
                    qcnt_nx = qcnt + 3'd1;
                    if (qcnt >= FILT_M1) begin
                        enter    = 1'b1;
                        state_nx = ACTIVE;
                    end
                end else begin
                    glitch   = 1'b1;
                    state_nx = IDLE;
                end
            end
            ACTIVE: begin
                if (!act) begin
                    leave    = 1'b1;
                    rcnt_nx  = 3'd1;
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                // a re-assertion here is ringing on the old strobe
                if (act) begin
                    rcnt_nx = 3'd0;
                end else if (rcnt >= FILT_M1) begin
                    state_nx = IDLE;
                end else begin
                    rcnt_nx = rcnt + 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // With FILT = 1 the cycle is entered straight from IDLE,
    // before the shadow registers hold the sample.
    assign src   = (state == IDLE) ? strb : sh;
    assign src_a = (state == IDLE) ? a_s  : sh_a;
    assign src_d = (state == IDLE) ? d_s  : sh_d;

    assign wr_l = ~src[1];
    assign both = ~src[0] & wr_l;
    assign rd_l = ~src[0] & ~wr_l;

    always_comb begin
        kind = K_UNDF;
        if (!src[2]) begin
            if (!src[4] && rd_l) kind = K_M1;
            else if (rd_l)       kind = K_MRD;
            else                 kind = K_MWR;
        end else if (!src[3]) begin
            kind = rd_l ? K_IORD : K_IOWR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh            <= '1;
            sh_a          <= '0;
            sh_d          <= '0;
            zb.bus_a      <= '0;
            zb.bus_d      <= '0;
            zb.bus_rd_n   <= 1'b1;
            zb.bus_wr_n   <= 1'b1;
            zb.bus_mreq_n <= 1'b1;
            zb.bus_iorq_n <= 1'b1;
            zb.bus_m1_n   <= 1'b1;
            zb.cyc_start  <= 1'b0;
            zb.cyc_end    <= 1'b0;
            zb.cyc_kind   <= K_IDLE;
            zb.glitch_cnt <= '0;
            zb.err_cnt    <= '0;
        end else begin
            zb.cyc_start <= 1'b0;
            zb.cyc_end   <= 1'b0;
            if (latch) begin
                sh   <= strb;
                sh_a <= a_s;
                sh_d <= d_s;
            end
            if (enter) begin
                zb.bus_a      <= src_a;
                if (wr_l) zb.bus_d <= src_d;
                zb.bus_rd_n   <= ~rd_l;
                zb.bus_wr_n   <= src[1];
                zb.bus_mreq_n <= src[2];
                zb.bus_iorq_n <= src[3];
                zb.bus_m1_n   <= src[4];
                zb.cyc_kind   <= kind;
                zb.cyc_start  <= 1'b1;
                if (both && zb.err_cnt != 8'hff)
                    zb.err_cnt <= zb.err_cnt + 8'd1;
            end
            if (leave) begin
                zb.bus_rd_n   <= 1'b1;
                zb.bus_wr_n   <= 1'b1;
                zb.bus_mreq_n <= 1'b1;
                zb.bus_iorq_n <= 1'b1;
                zb.bus_m1_n   <= 1'b1;
                zb.cyc_kind   <= K_IDLE;
                zb.cyc_end    <= 1'b1;
            end
            if (glitch && zb.glitch_cnt != 8'hff)
                zb.glitch_cnt <= zb.glitch_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_z80_bus_sync.sv
// Scoreboard bench for z80_bus_sync: expected cycle records are queued
// when pins are driven and compared when cyc_start/cyc_end fire.
module tb_z80_bus_sync;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic [2:0]  kind;
        logic [4:0]  n;
        int          cyc;
    } start_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          cyc;
    } end_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_start = 0;
    int   n_end = 0;
    logic [7:0] exp_d = 8'h00;

    start_t sq[$];
    end_t   eq[$];

    z80_bus_sync_if zb();

    z80_bus_sync #(.SYNC_STAGES(2), .FILT(2)) dut (
        .clk(clk),
        .rst(rst),
        .zb (zb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [4:0] got_n;
    assign got_n = {zb.bus_m1_n, zb.bus_iorq_n, zb.bus_mreq_n,
                    zb.bus_wr_n, zb.bus_rd_n};

    always @(negedge clk) begin
        if (!rst) begin
            if (zb.cyc_start && zb.cyc_end) begin
                checks++;
                errors++;
                $display("FAIL overlap: start and end high at cyc %0d", cyc);
            end
            if (zb.cyc_start) begin
                n_start++;
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL start: unexpected cyc_start at %0d", cyc);
                end else begin
                    start_t r;
                    r = sq.pop_front();
                    if (zb.bus_a !== r.a || zb.bus_d !== r.d ||
                        zb.cyc_kind !== r.kind || got_n !== r.n ||
                        cyc != r.cyc) begin
                        errors++;
                        $display("FAIL start: got a=%h d=%h k=%0d n=%b c=%0d want a=%h d=%h k=%0d n=%b c=%0d",
                                 zb.bus_a, zb.bus_d, zb.cyc_kind, got_n, cyc,
                                 r.a, r.d, r.kind, r.n, r.cyc);
                    end
                end
            end
            if (zb.cyc_end) begin
                n_end++;
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL end: unexpected cyc_end at %0d", cyc);
                end else begin
                    end_t e;
                    e = eq.pop_front();
                    if (zb.bus_a !== e.a || zb.bus_d !== e.d ||
                        zb.cyc_kind !== 3'd0 || got_n !== 5'h1f ||
                        cyc != e.cyc) begin
                        errors++;
                        $display("FAIL end: got a=%h d=%h k=%0d n=%b c=%0d want a=%h d=%h k=0 n=11111 c=%0d",
                                 zb.bus_a, zb.bus_d, zb.cyc_kind, got_n, cyc,
                                 e.a, e.d, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pins_idle();
        zb.z80_rd   = 1'b1;
        zb.z80_wr   = 1'b1;
        zb.z80_mreq = 1'b1;
        zb.z80_iorq = 1'b1;
        zb.z80_m1   = 1'b1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sq.size() != 0 || eq.size() != 0) begin
            errors++;
            $display("FAIL %s drain: pending starts=%0d ends=%0d, want 0 0",
                     name, sq.size(), eq.size());
        end
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d,
                             input logic mreq, input logic iorq,
                             input logic m1, input logic rd,
                             input logic wr, input logic [2:0] kind,
                             input int hold);
        start_t r;
        end_t   e;
        zb.z80_a    = a;
        zb.z80_d_in = d;
        zb.z80_mreq = mreq;
        zb.z80_iorq = iorq;
        zb.z80_m1   = m1;
        zb.z80_rd   = rd;
        zb.z80_wr   = wr;
        if (!wr) exp_d = d;
        r.a    = a;
        r.d    = exp_d;
        r.kind = kind;
        r.n    = {m1, iorq, mreq, wr, (!rd && !wr) ? 1'b1 : rd};
        r.cyc  = cyc + 4;
        sq.push_back(r);
        if (hold >= 8) begin
            tick(6);
            zb.z80_a = ~a;
            tick(hold - 6);
        end else begin
            tick(hold);
        end
        zb.z80_rd = 1'b1;
        zb.z80_wr = 1'b1;
        e.a   = a;
        e.d   = exp_d;
        e.cyc = cyc + 3;
        eq.push_back(e);
        tick(1);
        pins_idle();
        tick(6);
    endtask

    task automatic test_reset();
        pins_idle();
        zb.z80_a    = 16'h0;
        zb.z80_d_in = 8'h0;
        rst = 1'b1;
        tick(3);
        checks++;
        if (zb.bus_a !== 16'h0 || zb.bus_d !== 8'h0) begin
            errors++;
            $display("FAIL reset_ad: a=%h d=%h want 0000 00",
                     zb.bus_a, zb.bus_d);
        end
        checks++;
        if (got_n !== 5'h1f || zb.cyc_kind !== 3'd0) begin
            errors++;
            $display("FAIL reset_strb: n=%b k=%0d want 11111 0",
                     got_n, zb.cyc_kind);
        end
        checks++;
        if (zb.cyc_start !== 1'b0 || zb.cyc_end !== 1'b0 ||
            zb.glitch_cnt !== 8'h0 || zb.err_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_cnt: s=%b e=%b g=%0d err=%0d want 0 0 0 0",
                     zb.cyc_start, zb.cyc_end, zb.glitch_cnt, zb.err_cnt);
        end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_mem_read();
        int s0;
        s0 = n_start;
        bus_cycle(16'h1234, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                  3'd2, 12);
        check_drained("mem_read");
        checks++;
        if (n_start - s0 != 1 || zb.glitch_cnt !== 8'h0) begin
            errors++;
            $display("FAIL mem_read: starts=%0d glitch=%0d want 1 0",
                     n_start - s0, zb.glitch_cnt);
        end
    endtask

    task automatic test_fetch_io();
        int s0, e0;
        s0 = n_start;
        e0 = n_end;
        bus_cycle(16'h0000, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                  3'd1, 8);
        checks++;
        if (zb.bus_d !== 8'h00) begin
            errors++;
            $display("FAIL fetch_d: d=%h want 00", zb.bus_d);
        end
        bus_cycle(16'h00e7, 8'ha5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                  3'd5, 8);
        check_drained("fetch_io");
        checks++;
        if (n_start - s0 != 2 || n_end - e0 != 2 || zb.bus_d !== 8'ha5) begin
            errors++;
            $display("FAIL fetch_io: starts=%0d ends=%0d d=%h want 2 2 a5",
                     n_start - s0, n_end - e0, zb.bus_d);
        end
    endtask

    task automatic test_error();
        bus_cycle(16'h8000, 8'h3c, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                  3'd3, 8);
        check_drained("error");
        checks++;
        if (zb.err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL err_cnt: got %0d want 1", zb.err_cnt);
        end
    endtask

    task automatic test_ringing();
        start_t r;
        end_t   e;
        int     s0;
        s0 = n_start;
        zb.z80_a    = 16'h4000;
        zb.z80_d_in = 8'h5a;
        zb.z80_mreq = 1'b0;
        zb.z80_wr   = 1'b0;
        exp_d = 8'h5a;
        r.a = 16'h4000; r.d = 8'h5a; r.kind = 3'd3;
        r.n = 5'b11001;  r.cyc = cyc + 4;
        sq.push_back(r);
        tick(8);
        zb.z80_wr = 1'b1;
        e.a = 16'h4000; e.d = 8'h5a; e.cyc = cyc + 3;
        eq.push_back(e);
        tick(1);
        zb.z80_wr = 1'b0;
        tick(4);
        zb.z80_wr = 1'b1;
        tick(3);
        zb.z80_a    = 16'h4001;
        zb.z80_d_in = 8'h77;
        zb.z80_wr   = 1'b0;
        exp_d = 8'h77;
        r.a = 16'h4001; r.d = 8'h77; r.cyc = cyc + 4;
        sq.push_back(r);
        tick(8);
        zb.z80_wr = 1'b1;
        e.a = 16'h4001; e.d = 8'h77; e.cyc = cyc + 3;
        eq.push_back(e);
        tick(1);
        pins_idle();
        tick(6);
        check_drained("ringing");
        checks++;
        if (n_start - s0 != 2 || zb.glitch_cnt !== 8'h0 ||
            zb.err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ringing: starts=%0d g=%0d err=%0d want 2 0 1",
                     n_start - s0, zb.glitch_cnt, zb.err_cnt);
        end
    endtask

    task automatic test_glitch();
        int s0;
        s0 = n_start;
        zb.z80_mreq = 1'b0;
        for (int i = 0; i < 300; i++) begin
            zb.z80_rd = 1'b0;
            tick(1);
            zb.z80_rd = 1'b1;
            tick(3);
            if (i == 0) begin
                checks++;
                if (zb.glitch_cnt !== 8'd1) begin
                    errors++;
                    $display("FAIL glitch_one: got %0d want 1",
                             zb.glitch_cnt);
                end
            end
        end
        pins_idle();
        tick(4);
        checks++;
        if (zb.glitch_cnt !== 8'hff || n_start != s0) begin
            errors++;
            $display("FAIL glitch_sat: g=%0d starts=%0d want 255 0",
                     zb.glitch_cnt, n_start - s0);
        end
    endtask

    task automatic test_reset_mid();
        start_t r;
        end_t   e;
        zb.z80_a    = 16'h2222;
        zb.z80_mreq = 1'b0;
        zb.z80_rd   = 1'b0;
        r.a = 16'h2222; r.d = exp_d; r.kind = 3'd2;
        r.n = 5'b11010;  r.cyc = cyc + 4;
        sq.push_back(r);
        tick(7);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (got_n !== 5'h1f || zb.bus_a !== 16'h0 || zb.bus_d !== 8'h0 ||
            zb.cyc_kind !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid: n=%b a=%h d=%h k=%0d want 11111 0000 00 0",
                     got_n, zb.bus_a, zb.bus_d, zb.cyc_kind);
        end
        checks++;
        if (zb.glitch_cnt !== 8'h0 || zb.err_cnt !== 8'h0) begin
            errors++;
            $display("FAIL rst_mid_cnt: g=%0d err=%0d want 0 0",
                     zb.glitch_cnt, zb.err_cnt);
        end
        exp_d = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        r.d = 8'h00; r.cyc = cyc + 4;
        sq.push_back(r);
        tick(8);
        zb.z80_rd = 1'b1;
        e.a = 16'h2222; e.d = 8'h00; e.cyc = cyc + 3;
        eq.push_back(e);
        tick(1);
        pins_idle();
        tick(6);
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_fetch_io();
        test_error();
        test_ringing();
        test_glitch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
